axil_cmd_master: RTL and testbench

AXI4-Lite single-outstanding master that sits directly upstream of the cbi980 AXI-Lite register slave. It converts a simple valid/ready command stream (debug UART, CPU shim, test sequencer) into legal AXI-Lite read and write transactions. It returns one response per command, carrying the response code and read data.

---
 rtl/axil_cmd_master.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master
//   AXI4-Lite single-outstanding master. Converts a valid/ready command stream
//   into AXI-Lite read or write transactions and returns one response per
//   command (response code plus read data).
//
//   Optional feature macro: AXIL_STATS_EN
//     When defined, adds stat_clr and three saturating STAT_W-bit counters:
//     stat_wr_cnt (B handshakes), stat_rd_cnt (R handshakes) and stat_err_cnt
//     (either handshake with a non-OKAY response). stat_clr wins over increments.
//
//   Ports
//     aclk, arst          clock, synchronous active-high reset
//     cmd_*               command stream in (cmd_ready decodes IDLE)
//     rsp_*               response stream out (registered)
//     busy                high whenever the FSM is not IDLE
//     m_aw*, m_w*, m_b*   AXI-Lite write address / data / response channels
//     m_ar*, m_r*         AXI-Lite read address / data channels
//     stat_*              statistics (AXIL_STATS_EN only)
module axil_cmd_master #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000,
  parameter int unsigned STAT_W = 16
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [1:0]        rsp_resp,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
`ifdef AXIL_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_wr_cnt,
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_err_cnt,
`endif
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  if (ADDR_W < 3 || STAT_W < 1) begin : g_param_chk
    $error("axil_cmd_master: ADDR_W must be >= 3 and STAT_W >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
  logic              m_awvalid_q, m_awvalid_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic              m_wvalid_q, m_wvalid_d;
  logic              m_bready_q, m_bready_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic              m_arvalid_q, m_arvalid_d;
  logic              m_rready_q, m_rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  // Word-aligned bus address: low two byte-address bits are always zero.
  logic [ADDR_W-1:0] aligned_addr;
  assign aligned_addr = cmd_addr & ~ADDR_W'(3);

  always_comb begin
    state_d     = state_q;
    m_awaddr_d  = m_awaddr_q;
    m_awvalid_d = m_awvalid_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    m_araddr_d  = m_araddr_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d     = WR_REQ;
            m_awaddr_d  = aligned_addr;
            m_awvalid_d = 1'b1;
            m_wdata_d   = cmd_wdata;
            m_wstrb_d   = cmd_wstrb;
            m_wvalid_d  = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
          end else begin
            state_d     = RD_REQ;
            m_araddr_d  = aligned_addr;
            m_arvalid_d = 1'b1;
          end
        end
      end

      WR_REQ: begin
        if (m_awvalid_q && m_awready) begin
          m_awvalid_d = 1'b0;
          aw_done_d   = 1'b1;
        end
        if (m_wvalid_q && m_wready) begin
          m_wvalid_d = 1'b0;
          w_done_d   = 1'b1;
        end
        // The _d flags fold in this cycle's handshakes, so simultaneous
        // AW/W acceptance moves on without an extra cycle.
        if (aw_done_d && w_done_d) begin
          state_d    = WR_RESP;
          m_bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (m_bvalid) begin
          state_d     = RSP;
          m_bready_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = m_bresp;
          rsp_rdata_d = '0;
        end
      end

      RD_REQ: begin
        if (m_arready) begin
          state_d     = RD_RESP;
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
        end
      end

      RD_RESP: begin
        if (m_rvalid) begin
          state_d     = RSP;
          m_rready_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = m_rresp;
          rsp_rdata_d = m_rdata;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q     <= IDLE;
      m_awaddr_q  <= '0;
      m_awvalid_q <= 1'b0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awvalid_q <= m_awvalid_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef AXIL_STATS_EN
  logic [STAT_W-1:0] stat_wr_cnt_q, stat_wr_cnt_d;
  logic [STAT_W-1:0] stat_rd_cnt_q, stat_rd_cnt_d;
  logic [STAT_W-1:0] stat_err_cnt_q, stat_err_cnt_d;
  logic              b_hs, r_hs, err_hs;

  assign b_hs   = (state_q == WR_RESP) && m_bvalid;
  assign r_hs   = (state_q == RD_RESP) && m_rvalid;
  assign err_hs = (b_hs && (m_bresp != 2'b00)) || (r_hs && (m_rresp != 2'b00));

  always_comb begin
    stat_wr_cnt_d  = stat_wr_cnt_q;
    stat_rd_cnt_d  = stat_rd_cnt_q;
    stat_err_cnt_d = stat_err_cnt_q;
    if (stat_clr) begin
      stat_wr_cnt_d  = '0;
      stat_rd_cnt_d  = '0;
      stat_err_cnt_d = '0;
    end else begin
      if (b_hs && (stat_wr_cnt_q != '1)) stat_wr_cnt_d = stat_wr_cnt_q + STAT_W'(1);
      if (r_hs && (stat_rd_cnt_q != '1)) stat_rd_cnt_d = stat_rd_cnt_q + STAT_W'(1);
      if (err_hs && (stat_err_cnt_q != '1)) stat_err_cnt_d = stat_err_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      stat_wr_cnt_q  <= '0;
      stat_rd_cnt_q  <= '0;
      stat_err_cnt_q <= '0;
    end else begin
      stat_wr_cnt_q  <= stat_wr_cnt_d;
      stat_rd_cnt_q  <= stat_rd_cnt_d;
      stat_err_cnt_q <= stat_err_cnt_d;
    end
  end

  assign stat_wr_cnt  = stat_wr_cnt_q;
  assign stat_rd_cnt  = stat_rd_cnt_q;
  assign stat_err_cnt = stat_err_cnt_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_rdata = rsp_rdata_q;

  assign m_awaddr  = m_awaddr_q;
  assign m_awprot  = PROT;
  assign m_awvalid = m_awvalid_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_wvalid  = m_wvalid_q;
  assign m_bready  = m_bready_q;
  assign m_araddr  = m_araddr_q;
  assign m_arprot  = PROT;
  assign m_arvalid = m_arvalid_q;
  assign m_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master. The bench plays the AXI-Lite slave
// (a word memory that echoes writes) and predicts, for each command, the exact
// cycle at which every valid/ready rises and falls from the chosen slave delays.
module tb_axil_cmd_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STAT_W = 3;
  localparam int unsigned STAT_MAX = (1 << STAT_W) - 1;

  logic              aclk, arst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [1:0]        rsp_resp;
  logic [31:0]       rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [2:0]        m_awprot, m_arprot;
  logic              m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_wstrb;
  logic [1:0]        m_bresp, m_rresp;
  logic              m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
`ifdef AXIL_STATS_EN
  logic              stat_clr;
  logic [STAT_W-1:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  axil_cmd_master #(
    .ADDR_W (ADDR_W),
    .PROT   (3'b000),
    .STAT_W (STAT_W)
  ) dut (
    .aclk      (aclk),
    .arst      (arst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_resp  (rsp_resp),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
`ifdef AXIL_STATS_EN
    .stat_clr     (stat_clr),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Slave memory (word-addressed by aligned byte address) and expected counters.
  logic [31:0] mem [logic [31:0]];
  int unsigned exp_wr = 0, exp_rd = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v < STAT_MAX) ? v + 1 : STAT_MAX;
  endfunction

  task automatic chk_stats();
`ifdef AXIL_STATS_EN
    chk("stat_wr_cnt", 32'(stat_wr_cnt), exp_wr);
    chk("stat_rd_cnt", 32'(stat_rd_cnt), exp_rd);
    chk("stat_err_cnt", 32'(stat_err_cnt), exp_err);
`endif
  endtask

  task automatic idle_inputs();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    rsp_ready = 1'b0;
`ifdef AXIL_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  task automatic chk_idle(input string tag);
    chkb({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chkb({tag, "_awvalid"}, m_awvalid, 1'b0);
    chkb({tag, "_wvalid"}, m_wvalid, 1'b0);
    chkb({tag, "_bready"}, m_bready, 1'b0);
    chkb({tag, "_arvalid"}, m_arvalid, 1'b0);
    chkb({tag, "_rready"}, m_rready, 1'b0);
  endtask

  // Runs one command starting at the current negedge (must be IDLE). Slave
  // readies fire exactly d_* cycles late; the response is held for 'stall'
  // cycles. Returns at the negedge of the first idle cycle afterwards.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int unsigned d_aw, input int unsigned d_w,
                         input int unsigned d_ar, input int unsigned d_resp,
                         input logic [1:0] resp, input int unsigned stall, input bit clr_hs);
    logic [31:0] al, cur;
    int unsigned t_aw, t_w, t_ar, t_rs, t_hs, t_rsp, t_end;
    al  = addr & 32'hFFFF_FFFC;
    cur = mem.exists(al) ? mem[al] : 32'h0;
    t_aw = 0; t_w = 0; t_ar = 0;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      t_aw = 1 + d_aw;
      t_w  = 1 + d_w;
      t_rs = ((t_aw > t_w) ? t_aw : t_w) + 1;
    end else begin
      t_ar = 1 + d_ar;
      t_rs = t_ar + 1;
    end
    t_hs  = t_rs + d_resp;
    t_rsp = t_hs + 1;
    t_end = t_rsp + stall;

    chkb("cmd_ready_before", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(1)); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom_range(15));

    for (int unsigned c = 1; c <= t_end; c++) begin
      chkb("busy", busy, 1'b1);
      chkb("cmd_ready", cmd_ready, 1'b0);
      chkb("awvalid", m_awvalid, c <= t_aw);
      chkb("wvalid", m_wvalid, c <= t_w);
      chkb("arvalid", m_arvalid, c <= t_ar);
      chkb("bready", m_bready, wr && c >= t_rs && c <= t_hs);
      chkb("rready", m_rready, !wr && c >= t_rs && c <= t_hs);
      chkb("rsp_valid", rsp_valid, c >= t_rsp);
      if (c <= t_aw) begin
        chk("awaddr", m_awaddr, al);
        chk("awprot", 32'(m_awprot), 0);
      end
      if (c <= t_w) begin
        chk("wdata", m_wdata, wd);
        chk("wstrb", 32'(m_wstrb), 32'(ws));
      end
      if (c <= t_ar) begin
        chk("araddr", m_araddr, al);
        chk("arprot", 32'(m_arprot), 0);
      end
      if (c >= t_rsp) begin
        chkb("rsp_write", rsp_write, wr);
        chk("rsp_resp", 32'(rsp_resp), 32'(resp));
        chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : cur);
      end
      m_awready = (c == t_aw) || (c > t_aw && 1'($urandom_range(1)));
      m_wready  = (c == t_w)  || (c > t_w  && 1'($urandom_range(1)));
      m_arready = (c == t_ar) || (c > t_ar && 1'($urandom_range(1)));
      m_bvalid  = wr && (c == t_hs);
      m_bresp   = (wr && c == t_hs) ? resp : 2'($urandom_range(3));
      m_rvalid  = !wr && (c == t_hs);
      m_rresp   = (!wr && c == t_hs) ? resp : 2'($urandom_range(3));
      m_rdata   = (!wr && c == t_hs) ? cur : $urandom;
      rsp_ready = (c == t_end) || (c < t_rsp && 1'($urandom_range(1)));
`ifdef AXIL_STATS_EN
      stat_clr  = clr_hs && (c == t_hs);
`endif
      @(negedge aclk);
    end
    idle_inputs();
    chk_idle("after_rsp");

    if (wr) mem[al] = cur;
    if (clr_hs) begin
      exp_wr = 0; exp_rd = 0; exp_err = 0;
    end else begin
      if (wr) exp_wr = sat_inc(exp_wr);
      else    exp_rd = sat_inc(exp_rd);
      if (resp != 2'b00) exp_err = sat_inc(exp_err);
    end
    chk_stats();
  endtask

  initial begin
    bit          r_wr, r_clr;
    logic [31:0] r_addr, r_wd;
    logic [3:0]  r_ws;
    logic [1:0]  r_resp;

    arst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    idle_inputs();
    repeat (3) @(negedge aclk);

    // Reset state
    chk_idle("reset");
    chk("reset_awaddr", m_awaddr, 0);
    chk("reset_wdata", m_wdata, 0);
    chk("reset_wstrb", 32'(m_wstrb), 0);
    chk("reset_araddr", m_araddr, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_resp", 32'(rsp_resp), 0);
    chkb("reset_rsp_write", rsp_write, 1'b0);
    chk_stats();
    arst = 1'b0;
    @(negedge aclk);

    // Read 0x8 with zero wait states: response at N+3
    mem[32'h8] = 32'h0000_001F;
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 1'b0);

    // Write 0x1F to 0x0B: AW immediate, W three cycles late
    run_cmd(1'b1, 32'h0B, 32'h1F, 4'hF, 0, 3, 0, 0, 2'b00, 0, 1'b0);

    // Clear statistics in idle, then a write answered with SLVERR
`ifdef AXIL_STATS_EN
    stat_clr = 1'b1;
    @(negedge aclk);
    stat_clr = 1'b0;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    chk_stats();
`endif
    run_cmd(1'b1, 32'h4, 32'hCAFE_F00D, 4'h5, 1, 0, 0, 1, 2'b10, 0, 1'b0);

    // Response backpressure for five cycles, next command right after
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 2, 1, 2'b00, 5, 1'b0);
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 0, 1'b0);

    // Reset while waiting for read data: abort, no response
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    @(negedge aclk);
    cmd_valid = 1'b0;
    m_arready = 1'b1;
    chkb("mid_arvalid", m_arvalid, 1'b1);
    @(negedge aclk);
    chkb("mid_rready", m_rready, 1'b1);
    chkb("mid_arvalid_low", m_arvalid, 1'b0);
    m_arready = 1'b0;
    arst = 1'b1;
    @(negedge aclk);
    chk_idle("mid_reset");
    arst = 1'b0;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    chk_stats();
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 1, 2, 2'b00, 0, 1'b0);

    // Back-to-back write then read of 0x0 (slave echoes)
    run_cmd(1'b1, 32'h0, 32'h1F, 4'hF, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 1'b0);

    // Randomized commands; clr_hs exercises clear-versus-increment
    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom_range(1));
      r_addr = ($urandom_range(1) != 0 ? 32'hA5A5_0000 : 32'h0) | 32'($urandom_range(31));
      r_wd   = $urandom;
      r_ws   = 4'($urandom_range(15));
      r_resp = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      r_clr  = ($urandom_range(9) == 0);
      run_cmd(r_wr, r_addr, r_wd, r_ws, $urandom_range(3), $urandom_range(3),
              $urandom_range(3), $urandom_range(3), r_resp, $urandom_range(3), r_clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
